// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit and receive paths.
// Optional clock glitch filter in ps2_line_sync is enabled by defining PS2_TX_FILTER_EN.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StDone,
        StErr
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-FF synchronisers, clock falling-edge detect, aligned data.
// With PS2_TX_FILTER_EN defined the clock is glitch-filtered (3 clk extra latency).
module ps2_line_sync (
    input  logic clk,
    input  logic clear,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic data_level,
    output logic clk_fall
);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_filt;
    logic       clk_prev;

    // Idle lines are high; resetting to 1 avoids a spurious edge after clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_filt;
        end
    end

`ifdef PS2_TX_FILTER_EN
    logic [2:0] clk_hist;
    logic       clk_filt_q;
    logic [2:0] data_dly;

    // Level moves only once the current and three previous samples agree.
    always_comb begin
        clk_filt = clk_filt_q;
        if (&{clk_hist, clk_sync[1]}) begin
            clk_filt = 1'b1;
        end else if (~|{clk_hist, clk_sync[1]}) begin
            clk_filt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            clk_hist   <= 3'b111;
            clk_filt_q <= 1'b1;
            data_dly   <= 3'b111;
        end else begin
            clk_hist   <= {clk_hist[1:0], clk_sync[1]};
            clk_filt_q <= clk_filt;
            data_dly   <= {data_dly[1:0], data_sync[1]};
        end
    end

    assign data_level = data_dly[2];
`else
    assign clk_filt   = clk_sync[1];
    assign data_level = data_sync[1];
`endif

    assign clk_fall = clk_prev & ~clk_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift frame, check ACK.
// Define PS2_TX_FILTER_EN to glitch-filter the incoming PS/2 clock.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned REQ_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned TIMER_MAX =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW = $clog2(TIMER_MAX + 1);
    localparam int unsigned SW = FRAME_BITS - 1;

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [SW-1:0] frame_q, frame_d;
    logic          doe_q, doe_d;
    logic          fall;
    logic          data_s;

    ps2_line_sync u_sync (
        .clk         (clk),
        .clear       (clear),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .data_level  (data_s),
        .clk_fall    (fall)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            bitcnt_q <= '0;
            frame_q  <= '0;
            doe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            frame_q  <= frame_d;
            doe_q    <= doe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bitcnt_d    = bitcnt_q;
        frame_d     = frame_q;
        doe_d       = doe_q;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    // Shift order: d0..d7, parity, stop.
                    frame_d = {1'b1, odd_parity(tx_data), tx_data};
                    timer_d = '0;
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                ps2_clk_oe = 1'b1;
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = StReq;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StReq: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (timer_q == TW'(REQ_CYCLES - 1)) begin
                    timer_d  = '0;
                    bitcnt_d = '0;
                    doe_d    = 1'b1;
                    state_d  = StShift;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StShift: begin
                ps2_data_oe = doe_q;
                if (fall) begin
                    timer_d  = '0;
                    doe_d    = ~frame_q[0];
                    frame_d  = {1'b0, frame_q[SW-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(FRAME_BITS - 2)) begin
                        state_d = StAck;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StAck: begin
                if (fall) begin
                    state_d = data_s ? StErr : StDone;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StDone: begin
                tx_done  = 1'b1;
                timer_d  = '0;
                bitcnt_d = '0;
                doe_d    = 1'b0;
                state_d  = StIdle;
            end
            StErr: begin
                tx_err   = 1'b1;
                timer_d  = '0;
                bitcnt_d = '0;
                doe_d    = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of command frames plus timeout, clear and hold sequences.
// Follows PS2_TX_FILTER_EN for the expected edge latency.
module tb_ps2_host_tx;

    localparam int unsigned INH = 300;
    localparam int unsigned REQ = 2;
    localparam int unsigned TO  = 800;
    localparam int          H   = 8;   // device half-period in clk cycles
`ifdef PS2_TX_FILTER_EN
    localparam int EDGE_LAT = 5;
`else
    localparam int EDGE_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       clear;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       ack_low;
        logic [9:0] exp_frame;  // {stop, parity, d7..d0}
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!clear) begin
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
            if (tx_done && tx_err) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_send(input logic [7:0] d);
        @(negedge clk);
        check("ready_idle", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        check("ready_drop", 32'(tx_ready), 32'd0);
    endtask

    // Entered on the first INHIBIT cycle; leaves on the first SHIFT cycle.
    task automatic preamble();
        int inh = 0;
        int req = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < int'(INH) + 10) begin
            inh++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(inh), 32'(INH));
        while (ps2_clk_oe && ps2_data_oe && req < 10) begin
            req++;
            @(negedge clk);
        end
        check("req_len", 32'(req), 32'(REQ));
        check("start_bit", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    endtask

    task automatic shift_edges(input int n, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            ps2_clk_in = 1'b0;
            repeat (H) @(negedge clk);
            bits[i] = ~ps2_data_oe;
            ps2_clk_in = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic ack_phase(input logic ack_low, input logic exp_done, input logic exp_err,
                             input int d0, input int e0);
        bit seen = 1'b0;
        ps2_data_in = ~ack_low;
        ps2_clk_in  = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = tx_done || tx_err;
        end
        check("pulse_seen", 32'(seen), 32'd1);
        check("tx_done", 32'(tx_done), 32'(exp_done));
        check("tx_err", 32'(tx_err), 32'(exp_err));
        check("oe_at_pulse", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        @(negedge clk);
        check("ready_after", 32'(tx_ready), 32'd1);
        check("oe_idle", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        check("done_count", 32'(done_cnt - d0), 32'(exp_done));
        check("err_count", 32'(err_cnt - e0), 32'(exp_err));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int d0, e0, n;

        clear = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        ps2_clk_in = 1'b1; ps2_data_in = 1'b1;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0};
        vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1'b1, 1'b0};
        vecs[2] = '{8'hED, 1'b0, 10'h3ED, 1'b0, 1'b1};  // device NACKs
        vecs[3] = '{8'h00, 1'b1, 10'h300, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 10'h201, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        clear = 1'b0;

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            start_send(vecs[i].data);
            tx_valid = 1'b0;
            preamble();
            shift_edges(10, bits);
            check("frame_bits", 32'(bits), 32'(vecs[i].exp_frame));
            ack_phase(vecs[i].ack_low, vecs[i].exp_done, vecs[i].exp_err, d0, e0);
        end

        // Device stops clocking after the 4th falling edge.
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hED);
        tx_valid = 1'b0;
        preamble();
        shift_edges(3, bits);
        ps2_clk_in = 1'b0;
        n = 0;
        while (!tx_err && n < int'(TO) + 50) begin
            @(negedge clk);
            n++;
            if (n == H) ps2_clk_in = 1'b1;
        end
        // Edge seen after sync latency; timer restarts on the following clk.
        check("timeout_latency", 32'(n), 32'(int'(TO) + EDGE_LAT + 1));
        check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        @(negedge clk);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_one_err", 32'(err_cnt - e0), 32'd1);

        // Clear while bit 5 (d4 = 0, data driven low) is on the bus.
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hA5);
        tx_valid = 1'b0;
        preamble();
        shift_edges(5, bits);
        check("pre_clear_data_oe", 32'(ps2_data_oe), 32'd1);
        clear = 1'b1;
        #1;
        check("clear_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        check("clear_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        check("clear_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hFF);
        tx_valid = 1'b0;
        preamble();
        shift_edges(10, bits);
        check("frame_ff", 32'(bits), 32'h3FF);
        ack_phase(1'b1, 1'b1, 1'b0, d0, e0);

        // tx_valid held with 0x55 through a 0xF4 frame.
        d0 = done_cnt; e0 = err_cnt;
        start_send(8'hF4);
        tx_data = 8'h55;
        preamble();
        shift_edges(10, bits);
        check("frame_hold_f4", 32'(bits), 32'h2F4);
        ack_phase(1'b1, 1'b1, 1'b0, d0, e0);
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        tx_valid = 1'b0;
        check("second_accept", 32'(tx_ready), 32'd0);
        preamble();
        shift_edges(10, bits);
        check("frame_hold_55", 32'(bits), 32'h355);
        ack_phase(1'b1, 1'b1, 1'b0, d0, e0);

        check("never_both", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
